// File: rtl/mbist_pkg.sv
// mbist_pkg: FSM and element types, per-element March C- tables (read
// expectation, write pattern, direction), the failure bit-code helper and
// the widths of the optional error-record fields (MBIST_ERRLOG_EN).
package mbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    E0 = 3'd0,
    E1 = 3'd1,
    E2 = 3'd2,
    E3 = 3'd3,
    E4 = 3'd4,
    E5 = 3'd5
  } elem_t;

  localparam logic [7:0] PAT_ZERO = 8'h00;
  localparam logic [7:0] PAT_ONE  = 8'hFF;

  // Error-record field widths: {cs one-hot, address, element, bit code}
  localparam int REC_CS_W   = 2;
  localparam int REC_ELEM_W = 3;
  localparam int REC_CODE_W = 4;

  // Every element except e0 starts a cell with a read
  function automatic logic elem_reads(input elem_t e);
    return (e != E0);
  endfunction

  // Every element except e5 ends a cell with a write
  function automatic logic elem_writes(input elem_t e);
    return (e != E5);
  endfunction

  // e3 and e4 walk the address space downwards
  function automatic logic elem_down(input elem_t e);
    return (e == E3) || (e == E4);
  endfunction

  // Byte expected by the read of each element
  function automatic logic [7:0] elem_rd_exp(input elem_t e);
    logic [7:0] v;
    case (e)
      E2, E4:  v = PAT_ONE;
      default: v = PAT_ZERO;
    endcase
    return v;
  endfunction

  // Byte written by the write of each element
  function automatic logic [7:0] elem_wr_pat(input elem_t e);
    logic [7:0] v;
    case (e)
      E1, E3:  v = PAT_ONE;
      default: v = PAT_ZERO;
    endcase
    return v;
  endfunction

  // One-hot write strobe for the lane under test
  function automatic logic [1:0] lane_strobe(input logic lane);
    return lane ? 2'b10 : 2'b01;
  endfunction

  // Single-bit syndrome -> bit index; multi-bit -> 8 + lowest set bit
  function automatic logic [3:0] bit_code(input logic [7:0] syn);
    logic [3:0] low;
    int         ones;
    low  = 4'd0;
    ones = 0;
    for (int i = 7; i >= 0; i--) begin
      if (syn[i]) low = 4'(i);
    end
    for (int i = 0; i < 8; i++) begin
      ones = ones + int'(syn[i]);
    end
    return (ones == 1) ? low : (4'd8 + low);
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// mbist_addr_gen: March cell walker. Holds the cell counter, current element
// and lane; exposes the current element/lane and the physical address,
// element and lane of the cell that follows a step.
module mbist_addr_gen import mbist_pkg::*; #(
  parameter int          AW    = 17,
  parameter int unsigned ADMAX = (1 << AW) - 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_step,
  output elem_t         o_elem,
  output logic          o_lane,
  output logic          o_last_run,
  output logic [AW-1:0] o_nxt_a,
  output elem_t         o_nxt_elem,
  output logic          o_nxt_lane
);

  localparam logic [AW-1:0] LAST = AW'(ADMAX);

  logic [AW-1:0] r_cnt;
  elem_t         r_elem;
  logic          r_lane;

  logic [AW-1:0] w_nxt_cnt;
  elem_t         w_nxt_elem;
  logic          w_nxt_lane;
  logic          w_last_cell;

  assign w_last_cell = (r_cnt == LAST);

  // Successor cell: counter wraps only at an element boundary, e5 rolls into the next lane
  always_comb begin
    w_nxt_cnt  = r_cnt + AW'(1);
    w_nxt_elem = r_elem;
    w_nxt_lane = r_lane;
    if (w_last_cell) begin
      w_nxt_cnt = '0;
      if (r_elem == E5) begin
        w_nxt_elem = E0;
        w_nxt_lane = 1'b1;
      end else begin
        w_nxt_elem = elem_t'(r_elem + 3'd1);
      end
    end
  end

  // Cell counter, element and lane registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_elem <= E0;
      r_lane <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= '0;
      r_elem <= E0;
      r_lane <= 1'b0;
    end else if (i_step) begin
      r_cnt  <= w_nxt_cnt;
      r_elem <= w_nxt_elem;
      r_lane <= w_nxt_lane;
    end
  end

  assign o_elem     = r_elem;
  assign o_lane     = r_lane;
  assign o_last_run = w_last_cell && (r_elem == E5) && r_lane;
  assign o_nxt_elem = w_nxt_elem;
  assign o_nxt_lane = w_nxt_lane;
  assign o_nxt_a    = elem_down(w_nxt_elem) ? (LAST - w_nxt_cnt) : w_nxt_cnt;

endmodule

// File: rtl/mbist_ctrl.sv
// mbist_ctrl: SRAM access controller plus March C- BIST sequencer.
// Host accesses are served in IDLE only; a BIST run covers the low byte lane,
// then the high byte lane. All SRAM control outputs are registered so each
// access is stable for a whole cycle; read data is compared in the RD cycle.
// Optional feature macro: MBIST_ERRLOG_EN adds err_valid / err_rec.
module mbist_ctrl import mbist_pkg::*; #(
  parameter int          AW    = 17,
  parameter int unsigned ADMAX = (1 << AW) - 1,
  parameter int          ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [1:0]       host_be,
  input  logic [AW-1:0]    host_addr,
  input  logic [15:0]      host_wdata,
  output logic             host_gnt,
  output logic             host_rvalid,
  output logic [15:0]      host_rdata,
  output logic [AW-1:0]    sram_a,
  output logic             sram_oe,
  output logic [1:0]       sram_we,
  output logic [15:0]      sram_dout,
  input  logic [15:0]      sram_din,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef MBIST_ERRLOG_EN
  ,
  output logic             err_valid,
  output logic [REC_CS_W+AW+REC_ELEM_W+REC_CODE_W-1:0] err_rec
`endif
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t          r_state;
  logic [AW-1:0]   r_sram_a;
  logic            r_sram_oe;
  logic [1:0]      r_sram_we;
  logic [15:0]     r_sram_dout;
  logic            r_host_gnt;
  logic            r_host_rvalid;
  logic [15:0]     r_host_rdata;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [ERR_W-1:0] r_err_cnt;

  state_t          w_state_next;
  logic [AW-1:0]   w_sram_a_next;
  logic            w_sram_oe_next;
  logic [1:0]      w_sram_we_next;
  logic [15:0]     w_sram_dout_next;
  logic            w_host_gnt_next;
  logic            w_busy_next;
  logic            w_done_next;
  logic            w_pass_next;
  logic [ERR_W-1:0] w_err_cnt_next;
  logic            w_ag_load;
  logic            w_ag_step;

  elem_t           w_elem;
  logic            w_lane;
  logic            w_last_run;
  logic [AW-1:0]   w_nxt_a;
  elem_t           w_nxt_elem;
  logic            w_nxt_lane;

  logic [7:0]      w_rd_byte;
  logic [7:0]      w_syndrome;
  logic            w_fail;

  mbist_addr_gen #(
    .AW    (AW),
    .ADMAX (ADMAX)
  ) u_addr_gen (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_load     (w_ag_load),
    .i_step     (w_ag_step),
    .o_elem     (w_elem),
    .o_lane     (w_lane),
    .o_last_run (w_last_run),
    .o_nxt_a    (w_nxt_a),
    .o_nxt_elem (w_nxt_elem),
    .o_nxt_lane (w_nxt_lane)
  );

  // Read data of the lane under test against the element's expected byte
  assign w_rd_byte  = w_lane ? sram_din[15:8] : sram_din[7:0];
  assign w_syndrome = w_rd_byte ^ elem_rd_exp(w_elem);
  assign w_fail     = (r_state == ST_RD) && (w_syndrome != 8'h00);

  // Next state, next SRAM access and status; each branch sets up the access of the following cycle
  always_comb begin
    w_state_next     = r_state;
    w_sram_a_next    = r_sram_a;
    w_sram_oe_next   = 1'b0;
    w_sram_we_next   = 2'b00;
    w_sram_dout_next = r_sram_dout;
    w_host_gnt_next  = 1'b0;
    w_busy_next      = r_busy;
    w_done_next      = r_done;
    w_pass_next      = r_pass;
    w_err_cnt_next   = r_err_cnt;
    w_ag_load        = 1'b0;
    w_ag_step        = 1'b0;

    if (abort) begin
      w_state_next = ST_IDLE;
      w_busy_next  = 1'b0;
      w_done_next  = 1'b0;
      w_pass_next  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // First access is always e0 write of cell 0, low lane
            w_ag_load        = 1'b1;
            w_state_next     = ST_WR;
            w_busy_next      = 1'b1;
            w_done_next      = 1'b0;
            w_pass_next      = 1'b0;
            w_err_cnt_next   = '0;
            w_sram_a_next    = '0;
            w_sram_we_next   = lane_strobe(1'b0);
            w_sram_dout_next = {2{elem_wr_pat(E0)}};
          end else if (host_req) begin
            w_host_gnt_next = 1'b1;
            w_sram_a_next   = host_addr;
            if (host_we) begin
              w_sram_we_next   = host_be;
              w_sram_dout_next = host_wdata;
            end else begin
              w_sram_oe_next = 1'b1;
            end
          end
        end

        ST_RD: begin
          if (w_fail && (r_err_cnt != ERR_MAX)) begin
            w_err_cnt_next = r_err_cnt + ERR_W'(1);
          end
          if (elem_writes(w_elem)) begin
            // Same cell, write half of the read-write pair
            w_state_next     = ST_WR;
            w_sram_we_next   = lane_strobe(w_lane);
            w_sram_dout_next = {2{elem_wr_pat(w_elem)}};
          end else if (w_last_run) begin
            w_state_next = ST_FIN;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
            w_pass_next  = (w_err_cnt_next == '0);
          end else begin
            w_ag_step     = 1'b1;
            w_sram_a_next = w_nxt_a;
            if (elem_reads(w_nxt_elem)) begin
              w_state_next   = ST_RD;
              w_sram_oe_next = 1'b1;
            end else begin
              w_state_next     = ST_WR;
              w_sram_we_next   = lane_strobe(w_nxt_lane);
              w_sram_dout_next = {2{elem_wr_pat(w_nxt_elem)}};
            end
          end
        end

        ST_WR: begin
          w_ag_step     = 1'b1;
          w_sram_a_next = w_nxt_a;
          if (elem_reads(w_nxt_elem)) begin
            w_state_next   = ST_RD;
            w_sram_oe_next = 1'b1;
          end else begin
            w_state_next     = ST_WR;
            w_sram_we_next   = lane_strobe(w_nxt_lane);
            w_sram_dout_next = {2{elem_wr_pat(w_nxt_elem)}};
          end
        end

        ST_FIN: begin
          w_state_next = ST_IDLE;
        end

        default: begin
          w_state_next = ST_IDLE;
          w_busy_next  = 1'b0;
        end
      endcase
    end
  end

  // State, registered SRAM controls and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_sram_a    <= '0;
      r_sram_oe   <= 1'b0;
      r_sram_we   <= 2'b00;
      r_sram_dout <= '0;
      r_host_gnt  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sram_a    <= w_sram_a_next;
      r_sram_oe   <= w_sram_oe_next;
      r_sram_we   <= w_sram_we_next;
      r_sram_dout <= w_sram_dout_next;
      r_host_gnt  <= w_host_gnt_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_pass      <= w_pass_next;
      r_err_cnt   <= w_err_cnt_next;
    end
  end

  // Capture host read data at the end of the granted read cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
    end else begin
      r_host_rvalid <= r_host_gnt && r_sram_oe;
      if (r_host_gnt && r_sram_oe) begin
        r_host_rdata <= sram_din;
      end
    end
  end

`ifdef MBIST_ERRLOG_EN
  logic                                         r_err_valid;
  logic [REC_CS_W+AW+REC_ELEM_W+REC_CODE_W-1:0] r_err_rec;

  // Failure record registered one cycle after the failing read; held until the next failure
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_valid <= 1'b0;
      r_err_rec   <= '0;
    end else begin
      r_err_valid <= w_fail && !abort;
      if (w_fail && !abort) begin
        r_err_rec <= {lane_strobe(w_lane), r_sram_a, 3'(w_elem), bit_code(w_syndrome)};
      end
    end
  end

  assign err_valid = r_err_valid;
  assign err_rec   = r_err_rec;
`endif

  assign host_gnt    = r_host_gnt;
  assign host_rvalid = r_host_rvalid;
  assign host_rdata  = r_host_rdata;
  assign sram_a      = r_sram_a;
  assign sram_oe     = r_sram_oe;
  assign sram_we     = r_sram_we;
  assign sram_dout   = r_sram_dout;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_mbist_ctrl.sv
// tb_mbist_ctrl: randomized host traffic and BIST runs over a 16-cell SRAM
// model with injectable stuck-at faults, checked against a behavioural
// March C- walk and a host-visible memory array kept in the bench.
// Define MBIST_ERRLOG_EN to also check the first error record.
module tb_mbist_ctrl;

  localparam int AW    = 4;
  localparam int N     = 1 << AW;
  localparam int ERR_W = 5;
  localparam int MAXC  = (1 << ERR_W) - 1;

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic             host_req;
  logic             host_we;
  logic [1:0]       host_be;
  logic [AW-1:0]    host_addr;
  logic [15:0]      host_wdata;
  logic             host_gnt;
  logic             host_rvalid;
  logic [15:0]      host_rdata;
  logic [AW-1:0]    sram_a;
  logic             sram_oe;
  logic [1:0]       sram_we;
  logic [15:0]      sram_dout;
  logic [15:0]      sram_din;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
`ifdef MBIST_ERRLOG_EN
  logic             err_valid;
  logic [2+AW+3+4-1:0] err_rec;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] mem      [N];
  logic [15:0] sa1      [N];
  logic [15:0] sa0      [N];
  logic [15:0] ref_host [N];

  mbist_ctrl #(.AW(AW), .ERR_W(ERR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_be    (host_be),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .sram_a     (sram_a),
    .sram_oe    (sram_oe),
    .sram_we    (sram_we),
    .sram_dout  (sram_dout),
    .sram_din   (sram_din),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt)
`ifdef MBIST_ERRLOG_EN
    ,
    .err_valid  (err_valid),
    .err_rec    (err_rec)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: stuck-at faults applied on read, per-lane byte writes
  assign sram_din = sram_oe ? ((mem[sram_a] | sa1[sram_a]) & ~sa0[sram_a]) : 16'h0000;
  always @(posedge clk) begin
    if (sram_we[0]) mem[sram_a][7:0]  <= sram_dout[7:0];
    if (sram_we[1]) mem[sram_a][15:8] <= sram_dout[15:8];
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout required normal end");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_bitcode(input logic [7:0] s);
    int low;
    low = -1;
    for (int i = 0; i < 8; i++) if (s[i] && low < 0) low = i;
    return ($countones(s) == 1) ? low : 8 + low;
  endfunction

  // Abstract March C- walk over the faulty memory; returns saturated count and first failure
  task automatic march_model(output int exp_errs, output int f_lane, output int f_addr,
                             output int f_elem, output int f_code);
    logic [15:0] m [N];
    logic [15:0] eff;
    logic [7:0]  got, expb, wv;
    int errs, a;
    errs = 0; f_lane = 0; f_addr = 0; f_elem = 0; f_code = 0;
    for (int i = 0; i < N; i++) m[i] = 16'h0000;
    for (int lane = 0; lane < 2; lane++) begin
      for (int e = 0; e < 6; e++) begin
        for (int k = 0; k < N; k++) begin
          a = (e == 3 || e == 4) ? (N - 1 - k) : k;
          if (e != 0) begin
            eff  = (m[a] | sa1[a]) & ~sa0[a];
            got  = (lane == 1) ? eff[15:8] : eff[7:0];
            expb = (e == 2 || e == 4) ? 8'hFF : 8'h00;
            if (got != expb) begin
              if (errs == 0) begin
                f_lane = lane; f_addr = a; f_elem = e; f_code = ref_bitcode(got ^ expb);
              end
              errs++;
            end
          end
          if (e != 5) begin
            wv = (e == 1 || e == 3) ? 8'hFF : 8'h00;
            if (lane == 1) m[a][15:8] = wv;
            else           m[a][7:0]  = wv;
          end
        end
      end
    end
    exp_errs = (errs > MAXC) ? MAXC : errs;
  endtask

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      sa1[i] = 16'h0000;
      sa0[i] = 16'h0000;
    end
  endtask

  task automatic run_bist(input string name, input bit hold_host, input bit poke_start);
    int exp_errs, fl, fa, fe, fc, cyc;
    bit gnt_seen, ev_seen;
    logic [2+AW+3+4-1:0] first_rec, exp_rec;
    march_model(exp_errs, fl, fa, fe, fc);
    ev_seen = 0; gnt_seen = 0; first_rec = '0;
    host_req = hold_host; host_we = 1'b0; host_addr = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 2000) begin
      cyc++;
      if (host_gnt) gnt_seen = 1;
`ifdef MBIST_ERRLOG_EN
      if (err_valid && !ev_seen) begin ev_seen = 1; first_rec = err_rec; end
`endif
      start = (poke_start && cyc == 30);
      @(posedge clk); #1;
    end
    start = 1'b0;
`ifdef MBIST_ERRLOG_EN
    if (err_valid && !ev_seen) begin ev_seen = 1; first_rec = err_rec; end
    exp_rec = {(fl == 1) ? 2'b10 : 2'b01, AW'(fa), 3'(fe), 4'(fc)};
    check_eq({name, "_errlog_seen"}, 32'(ev_seen), 32'(exp_errs != 0));
    if (exp_errs != 0) check_eq({name, "_err_rec"}, 32'(first_rec), 32'(exp_rec));
`endif
    check_eq({name, "_busy_len"}, cyc, 20 * N);
    check_eq({name, "_done"}, 32'(done), 32'd1);
    check_eq({name, "_pass"}, 32'(pass), 32'(exp_errs == 0));
    check_eq({name, "_err_cnt"}, 32'(err_cnt), exp_errs);
    check_eq({name, "_host_gnt_busy"}, 32'(gnt_seen), 32'd0);
    host_req = 1'b0;
    @(posedge clk); #1;
    check_eq({name, "_done_hold"}, 32'(done), 32'd1);
    $display("bist %s: busy_cycles=%0d err_cnt=%0d pass=%0d expected_errs=%0d",
             name, cyc, err_cnt, pass, exp_errs);
  endtask

  task automatic host_op(input bit we, input logic [1:0] be, input logic [AW-1:0] addr,
                         input logic [15:0] data);
    host_req = 1'b1; host_we = we; host_be = be; host_addr = addr; host_wdata = data;
    @(posedge clk); #1;
    host_req = 1'b0;
    check_eq("host_gnt", 32'(host_gnt), 32'd1);
    check_eq("host_sram_a", 32'(sram_a), 32'(addr));
    check_eq("host_sram_we", 32'(sram_we), we ? 32'(be) : 32'd0);
    check_eq("host_sram_oe", 32'(sram_oe), 32'(!we));
    if (we) begin
      if (be[0]) ref_host[addr][7:0]  = data[7:0];
      if (be[1]) ref_host[addr][15:8] = data[15:8];
    end
    @(posedge clk); #1;
    check_eq("host_rvalid", 32'(host_rvalid), 32'(!we));
    if (!we) check_eq("host_rdata", 32'(host_rdata), 32'(ref_host[addr]));
    $display("host %s a=%0d be=%b wdata=%h rdata=%h", we ? "wr" : "rd", addr, be, data, host_rdata);
  endtask

  task automatic host_rd_pair(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    host_req = 1'b1; host_we = 1'b0; host_addr = a0;
    @(posedge clk); #1;
    host_addr = a1;
    check_eq("b2b_gnt0", 32'(host_gnt), 32'd1);
    @(posedge clk); #1;
    host_req = 1'b0;
    check_eq("b2b_gnt1", 32'(host_gnt), 32'd1);
    check_eq("b2b_rdata0", 32'(host_rdata), 32'(ref_host[a0]));
    @(posedge clk); #1;
    check_eq("b2b_rvalid1", 32'(host_rvalid), 32'd1);
    check_eq("b2b_rdata1", 32'(host_rdata), 32'(ref_host[a1]));
    $display("host b2b rd a0=%0d a1=%0d", a0, a1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_be = 2'b00; host_addr = '0; host_wdata = '0;
    clear_faults();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_pass", 32'(pass), 0);
    check_eq("rst_err_cnt", 32'(err_cnt), 0);
    check_eq("rst_sram_we", 32'(sram_we), 0);
    check_eq("rst_sram_oe", 32'(sram_oe), 0);
    check_eq("rst_host_gnt", 32'(host_gnt), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Host: fill every cell, then random traffic, then the fixed pattern
    for (int i = 0; i < N; i++) host_op(1'b1, 2'b11, AW'(i), 16'($urandom));
    for (int i = 0; i < 24; i++)
      host_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), AW'($urandom_range(0, N - 1)),
              16'($urandom));
    host_rd_pair(AW'($urandom_range(0, N - 1)), AW'($urandom_range(0, N - 1)));
    host_op(1'b1, 2'b11, 4'd7, 16'hA55A);
    host_op(1'b0, 2'b11, 4'd7, 16'h0000);

    // Fault-free run with host held off and a start poked mid-run
    run_bist("clean", 1'b1, 1'b1);

    // Low-lane bit 3 stuck at 1 at address 5
    sa1[5] = 16'h0008;
    run_bist("sa1_a5_b3", 1'b0, 1'b0);
    clear_faults();

    // Random stuck-at faults
    for (int r = 0; r < 3; r++) begin
      clear_faults();
      for (int k = 0; k < 3; k++) begin
        int a;
        a = $urandom_range(0, N - 1);
        sa1[a] = sa1[a] | 16'($urandom_range(0, 65535) & $urandom_range(0, 65535));
        sa0[a] = sa0[a] | (16'($urandom_range(0, 65535) & $urandom_range(0, 65535)) & ~sa1[a]);
      end
      run_bist("random", 1'($urandom_range(0, 1)), 1'b0);
    end

    // Whole high lane stuck at 0xFF saturates the counter
    clear_faults();
    for (int i = 0; i < N; i++) sa1[i] = 16'hFF00;
    run_bist("hi_lane_ff", 1'b0, 1'b0);
    clear_faults();

    // abort 100 cycles into a run
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_sram_we", 32'(sram_we), 0);
    check_eq("abort_sram_oe", 32'(sram_oe), 0);
    check_eq("abort_done", 32'(done), 0);
    $display("abort after 100 cycles: busy=%0d done=%0d", busy, done);

    // abort and start together in IDLE: abort wins
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    check_eq("abort_start_busy", 32'(busy), 0);
    @(posedge clk); #1;
    check_eq("abort_start_busy2", 32'(busy), 0);
    run_bist("after_abort", 1'b0, 1'b0);

    // Reset in the middle of a run
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check_eq("midrst_busy", 32'(busy), 0);
    check_eq("midrst_sram_we", 32'(sram_we), 0);
    check_eq("midrst_sram_oe", 32'(sram_oe), 0);
    check_eq("midrst_err_cnt", 32'(err_cnt), 0);
    $display("reset mid-run: busy=%0d sram_we=%b", busy, sram_we);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_bist("after_reset", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
